// File: rtl/rx_mod_pkg.sv
// rx_mod_pkg: UART link definitions shared by the receive and transmit stages.
package rx_mod_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/rx_mod_sampler.sv
// rx_sampler: line synchronizer, per-bit sample counter and 3-sample majority vote.
module rx_sampler
  import rx_mod_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic rxd,
  input  logic run,
  output logic rxd_s,
  output logic bit_val,
  output logic decide,
  output logic eob
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_A = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_L = SW'(OVERSAMPLE - 1);
  logic s1_q, s1_d, s2_q, s2_d, m0_q, m0_d, m1_q, m1_d, tick;
  logic [SW-1:0] scnt_q, scnt_d;
  assign tick = bclk & run;
  assign rxd_s = s2_q;
  always_comb begin
    s1_d = rxd;
    s2_d = s1_q;
    scnt_d = !run ? '0 : tick ? (scnt_q == S_L ? '0 : scnt_q + 1'b1) : scnt_q;
    m0_d = (tick && scnt_q == S_A) ? s2_q : m0_q;
    m1_d = (tick && scnt_q == S_B) ? s2_q : m1_q;
    bit_val = maj3(m0_q, m1_q, s2_q);
    decide = tick && scnt_q == S_C;
    eob = tick && scnt_q == S_L;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      m0_q <= 1'b0;
      m1_q <= 1'b0;
      scnt_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      m0_q <= m0_d;
      m1_q <= m1_d;
      scnt_q <= scnt_d;
    end
  end
endmodule

// File: rtl/rx_mod.sv
// rx_mod: UART receiver with frame FSM, shift register and ready/ack byte handshake.
module rx_mod
  import rx_mod_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_rdy,
  output logic                 frm_err,
  output logic                 ovr_err
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] B_L = BW'(DATA_BITS - 1);
  rx_state_t state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
  logic rdy_q, rdy_d, frm_q, frm_d, ovr_q, ovr_d;
  logic rxd_s, bit_val, decide, eob, run, dlv;
  assign run = state_q inside {START, DATA, STOP};
  rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_smp (
    .clk(clk),
    .rst(rst),
    .bclk(bclk),
    .rxd(rxd),
    .run(run),
    .rxd_s(rxd_s),
    .bit_val(bit_val),
    .decide(decide),
    .eob(eob)
  );
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    shift_d = (decide && state_q == DATA) ? {bit_val, shift_q[DATA_BITS-1:1]} : shift_q;
    dlv = decide && state_q == STOP && bit_val == STOP_BIT;
    dout_d = dlv ? shift_q : dout_q;
    rdy_d = dlv | (rdy_q & ~rd);
    ovr_d = dlv & rdy_q & ~rd;
    frm_d = decide && state_q == STOP && bit_val != STOP_BIT;
    case (state_q)
      IDLE:  if (bclk && rxd_s == START_BIT) state_d = START;
      START: if (decide && bit_val != START_BIT) state_d = IDLE;
             else if (eob) begin
               state_d = DATA;
               bcnt_d = '0;
             end
      DATA:  if (eob) begin
               bcnt_d = bcnt_q + 1'b1;
               state_d = bcnt_q == B_L ? STOP : DATA;
             end
      // deciding mid stop bit leaves its second half to catch the next start edge
      STOP:  if (decide) state_d = bit_val == STOP_BIT ? IDLE : BREAK;
      BREAK: if (bclk && rxd_s == STOP_BIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      shift_q <= '0;
      dout_q <= '0;
      rdy_q <= 1'b0;
      frm_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      dout_q <= dout_d;
      rdy_q <= rdy_d;
      frm_q <= frm_d;
      ovr_q <= ovr_d;
    end
  end
  assign dout = dout_q;
  assign rx_rdy = rdy_q;
  assign frm_err = frm_q;
  assign ovr_err = ovr_q;
endmodule
